// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, branch funct3 codes, default NOP.
package rv32i_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    TRAP = 3'd4
  } pc_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pc_target.sv
// Combinational next-PC selection: branch resolution, target arithmetic and
// word-alignment check of the chosen target.
module pc_target
  import rv32i_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        is_branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  comp_sel_i,
  input  logic        eq_i,
  input  logic        lt_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic        taken;
  logic [31:0] pc_rel;
  logic [31:0] reg_rel;

  assign pc_rel  = pc_i + imm_i;
  assign reg_rel = (rs1_i + imm_i) & ~32'h1;

  // Branch outcome from funct3; the comparator already inverts lt for BGE/BGEU.
  always_comb begin
    taken = 1'b0;
    case (comp_sel_i)
      F3_BEQ:                             taken = eq_i;
      F3_BNE:                             taken = ~eq_i;
      F3_BLT, F3_BGE, F3_BLTU, F3_BGEU:   taken = lt_i;
      default:                            taken = 1'b0;
    endcase
  end

  // Target priority: JAL, JALR, taken branch, sequential.
  always_comb begin
    target_o = pc_i + 32'd4;
    if (is_jal_i)                  target_o = pc_rel;
    else if (is_jalr_i)            target_o = reg_rel;
    else if (is_branch_i && taken) target_o = pc_rel;
  end

  assign misalign_o = |target_o[1:0];

endmodule

// File: rtl/next_pc_unit.sv
// Instruction fetch / next-PC stage: owns the PC, runs the req/gnt/rvalid
// handshake to instruction memory and holds one instruction for execute.
//
// state | meaning
// BOOT  | first cycle out of reset, no request yet
// REQ   | imem_req high at pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// EXEC  | instruction held for execute, consumed on !stall
// TRAP  | misaligned target seen, halted until reset
module next_pc_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  comp_sel,
  input  logic        eq,
  input  logic        lt,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        misalign_err
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] target;
  logic        misalign;

  pc_target u_pc_target (
    .pc_i        (pc_q),
    .is_branch_i (is_branch),
    .is_jal_i    (is_jal),
    .is_jalr_i   (is_jalr),
    .comp_sel_i  (comp_sel),
    .eq_i        (eq),
    .lt_i        (lt),
    .imm_i       (imm),
    .rs1_i       (rs1),
    .target_o    (target),
    .misalign_o  (misalign)
  );

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; pc only moves on an aligned consume.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ:  if (imem_gnt) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          instr_d = NOP_INSTR;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = TRAP;
          end else begin
            pc_d    = target;
            state_d = REQ;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  assign imem_req     = (state_q == REQ);
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == EXEC);
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit; the bench plays instruction memory and
// execute. Inputs change and outputs are sampled on the falling edge.
module tb_next_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, pc, pc_plus4;
  logic        stall, is_branch, is_jal, is_jalr, eq, lt;
  logic [2:0]  comp_sel;
  logic [31:0] imm, rs1;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  next_pc_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .is_branch    (is_branch),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .comp_sel     (comp_sel),
    .eq           (eq),
    .lt           (lt),
    .imm          (imm),
    .rs1          (rs1),
    .misalign_err (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Drives one fetch starting at a falling edge in REQ; returns in EXEC.
  task automatic fetch(input logic [31:0] exp_addr, input int gnt_dly,
                       input bit pulse_rv, output int req_cyc);
    logic [31:0] data;
    data    = exp_addr ^ 32'hDEAD_0000;
    req_cyc = cyc;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req @%h: got %b expected 1", exp_addr, imem_req); end
    n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_addr); end
    for (int i = 0; i < gnt_dly; i++) begin
      if (pulse_rv && i == 0) begin imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; end
      @(negedge clk);
      imem_rvalid = 1'b0;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_fail++; $display("FAIL gnt_wait_stable: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL gnt_wait_valid: got %b expected 0", instr_valid); end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_state: got req=%b valid=%b expected 0 0", imem_req, instr_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL exec_valid: got %b expected 1", instr_valid); end
    n_checks++; if (instr !== data) begin n_fail++; $display("FAIL exec_instr: got %h expected %h", instr, data); end
    n_checks++; if (pc !== exp_addr) begin n_fail++; $display("FAIL exec_pc: got %h expected %h", pc, exp_addr); end
  endtask

  // Presents decoded control for one consume cycle from EXEC.
  task automatic consume(input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic e, input logic l,
                         input logic [31:0] im, input logic [31:0] r);
    stall = 1'b0; is_branch = br; is_jal = jal; is_jalr = jalr;
    comp_sel = f3; eq = e; lt = l; imm = im; rs1 = r;
    @(negedge clk);
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    comp_sel = 3'b000; eq = 1'b0; lt = 1'b0; imm = 32'h0; rs1 = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    comp_sel = 3'b000; eq = 1'b0; lt = 1'b0; imm = 32'h0; rs1 = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
    n_checks++; if (pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, 32'h104); end
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", misalign_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequential();
    int c0, c1, c2;
    fetch(32'h100, 0, 1'b0, c0);
    consume(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h104, 0, 1'b0, c1);
    consume(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h108, 0, 1'b0, c2);
    n_checks++; if (c1 - c0 != 3) begin n_fail++; $display("FAIL seq_spacing_1: got %0d expected 3", c1 - c0); end
    n_checks++; if (c2 - c1 != 3) begin n_fail++; $display("FAIL seq_spacing_2: got %0d expected 3", c2 - c1); end
    n_checks++; if (pc_plus4 !== 32'h10C) begin n_fail++; $display("FAIL seq_pc_plus4: got %h expected %h", pc_plus4, 32'h10C); end
    // JAL +0xF8 from 0x108 lands on 0x200
    consume(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_00F8, 32'h0);
  endtask

  task automatic test_branch();
    int c;
    fetch(32'h200, 0, 1'b0, c);
    consume(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);  // BNE taken
    fetch(32'h1F8, 0, 1'b0, c);
    consume(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_0008, 32'h0);  // JAL back to 0x200
    fetch(32'h200, 0, 1'b0, c);
    consume(1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);  // BNE not taken
    fetch(32'h204, 0, 1'b0, c);
    consume(1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 32'h0000_0010, 32'h0);  // BLT taken
    fetch(32'h214, 0, 1'b0, c);
    consume(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h0000_0010, 32'h0);  // reserved f3: not taken
    fetch(32'h218, 0, 1'b0, c);
    consume(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_1003);  // JALR clears bit 0
  endtask

  task automatic test_gnt_delay();
    int c;
    fetch(32'h1004, 4, 1'b1, c);
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = 32'h1004 ^ 32'hDEAD_0000;
    stall = 1'b1; is_jal = 1'b1; imm = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b1 || instr !== held || pc !== 32'h1004) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h expected 1 %h %h", i, instr_valid, instr, pc, held, 32'h1004);
      end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
    end
    stall = 1'b0; is_jal = 1'b0; imm = 32'h0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1008) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, 32'h1008); end
    n_checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL stall_release_instr: got valid=%b instr=%h expected 0 %h", instr_valid, instr, NOP); end
  endtask

  task automatic test_reset_in_wait();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    n_checks++; if (imem_req !== 1'b0 || pc !== 32'h1008) begin n_fail++; $display("FAIL rstwait_pre: got req=%b pc=%h expected 0 %h", imem_req, pc, 32'h1008); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== RST_PC || imem_addr !== RST_PC) begin n_fail++; $display("FAIL rstwait_pc: got pc=%h addr=%h expected %h", pc, imem_addr, RST_PC); end
    n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_outputs: got req=%b valid=%b instr=%h err=%b expected 0 0 %h 0", imem_req, instr_valid, instr, misalign_err, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL rstwait_first_req: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_misalign();
    int c;
    fetch(32'h100, 0, 1'b0, c);
    consume(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_1003);  // target 0x1006
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b expected 1", misalign_err); end
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL misalign_pc: got %h expected %h", pc, 32'h100); end
    n_checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL misalign_instr: got valid=%b instr=%h expected 0 %h", instr_valid, instr, NOP); end
    for (int i = 0; i < 5; i++) begin
      imem_gnt = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0 || misalign_err !== 1'b1 || pc !== 32'h100) begin
        n_fail++; $display("FAIL trap_hold[%0d]: got req=%b err=%b pc=%h expected 0 1 %h", i, imem_req, misalign_err, pc, 32'h100);
      end
    end
    imem_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_gnt_delay();
    test_stall();
    test_reset_in_wait();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
